// File: rtl/d_phy_multi_lane_receiver.sv
// ---------------------------------------------------------------------------
// d_phy_multi_lane_receiver
//
// Multi-lane HS receiver. Each lane shifts in one bit per sample_valid, LSB
// first. Each lane hunts for SYNC_BYTE on its own. Once a lane has found it,
// the lane frames a byte every 8 samples and pushes the byte into a small
// per-lane deskew FIFO. When every FIFO holds at least one byte, one byte is
// popped from each FIFO on the same edge. The popped bytes form the output
// word.
//
// State | meaning
// ------+---------------------------------------------------------------
// HUNT    | no lane has seen SYNC_BYTE yet
// PARTIAL | some lanes synced, waiting for the remaining lanes
// LOCKED  | all lanes synced, words stream out
// ERROR   | a lane overran its deskew FIFO; held until stop
//
// Ports
//   clock        bit-rate clock, rising edge
//   reset_n      asynchronous active-low reset
//   sample_valid one HS bit per lane on lane_bits this cycle
//   lane_bits    HS bit per lane, bit i = lane i
//   stop         synchronous end-of-burst clear
//   data         aligned word, [8i+7:8i] = lane i
//   enable       one-cycle pulse per output word
//   locked       all lanes synchronized
//   sync_error   sticky lane-skew overflow
// ---------------------------------------------------------------------------
module d_phy_multi_lane_receiver #(
    parameter int          LANES      = 2,
    parameter int          SKEW_BYTES = 2,
    parameter logic [7:0]  SYNC_BYTE  = 8'hB8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 sample_valid,
    input  logic [LANES-1:0]     lane_bits,
    input  logic                 stop,
    output logic [8*LANES-1:0]   data,
    output logic                 enable,
    output logic                 locked,
    output logic                 sync_error
);

    localparam int CW = $clog2(SKEW_BYTES + 1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [7:0]        shift_q   [LANES];
    logic [7:0]        shift_d   [LANES];
    logic [2:0]        bit_cnt_q [LANES];
    logic [2:0]        bit_cnt_d [LANES];
    logic [LANES-1:0]  synced_q, synced_d;
    logic [7:0]        fifo_q    [LANES][SKEW_BYTES];
    logic [7:0]        fifo_d    [LANES][SKEW_BYTES];
    logic [CW-1:0]     fill_q    [LANES];
    logic [CW-1:0]     fill_d    [LANES];
    logic [CW-1:0]     wr_idx    [LANES];
    logic [8*LANES-1:0] data_q, data_d, head_word;
    logic              enable_q, enable_d;

    logic [LANES-1:0]  sync_hit, byte_done, push, overflow;
    logic [LANES-1:0]  fifo_full, fifo_nonempty;
    logic              sample, pop;

    // ERROR freezes the lanes, and stop overrides sample_valid.
    always_comb begin
        fifo_full     = '0;
        fifo_nonempty = '0;
        head_word     = '0;
        for (int i = 0; i < LANES; i++) begin
            fifo_full[i]        = (fill_q[i] == CW'(SKEW_BYTES));
            fifo_nonempty[i]    = (fill_q[i] != '0);
            head_word[8*i +: 8] = fifo_q[i][0];
        end
        sample = sample_valid & ~stop & (state_q != ST_ERROR);
        pop    = (&fifo_nonempty) & ~stop & (state_q != ST_ERROR);
    end

    // Per-lane framing. Bits are matched against SYNC_BYTE only while the
    // lane is still hunting. This stops payload bytes from moving the byte
    // phase.
    always_comb begin
        sync_hit  = '0;
        byte_done = '0;
        push      = '0;
        overflow  = '0;
        synced_d  = synced_q;
        for (int i = 0; i < LANES; i++) begin
            shift_d[i]   = shift_q[i];
            bit_cnt_d[i] = bit_cnt_q[i];
            if (stop) begin
                shift_d[i]   = 8'h00;
                bit_cnt_d[i] = 3'd0;
                synced_d[i]  = 1'b0;
            end else if (sample) begin
                shift_d[i] = {lane_bits[i], shift_q[i][7:1]};
                if (!synced_q[i]) begin
                    if (shift_d[i] == SYNC_BYTE) begin
                        sync_hit[i]  = 1'b1;
                        synced_d[i]  = 1'b1;
                        bit_cnt_d[i] = 3'd0;
                    end
                end else begin
                    bit_cnt_d[i] = bit_cnt_q[i] + 3'd1;
                    byte_done[i] = (bit_cnt_q[i] == 3'd7);
                end
            end
            // A full FIFO can still accept a byte if it is popped on the same edge.
            overflow[i] = byte_done[i] & fifo_full[i] & ~pop;
            push[i]     = byte_done[i] & ~overflow[i];
        end
    end

    // Shift-down FIFO: the head is always entry 0.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            fill_d[i] = fill_q[i];
            wr_idx[i] = pop ? (fill_q[i] - CW'(1)) : fill_q[i];
            for (int j = 0; j < SKEW_BYTES; j++) begin
                fifo_d[i][j] = fifo_q[i][j];
            end
            if (stop) begin
                fill_d[i] = '0;
            end else begin
                if (pop) begin
                    for (int j = 0; j < SKEW_BYTES - 1; j++) begin
                        fifo_d[i][j] = fifo_q[i][j+1];
                    end
                end
                if (push[i]) begin
                    for (int j = 0; j < SKEW_BYTES; j++) begin
                        if (CW'(j) == wr_idx[i]) begin
                            fifo_d[i][j] = shift_d[i];
                        end
                    end
                end
                if (push[i] && !pop) begin
                    fill_d[i] = fill_q[i] + CW'(1);
                end else if (!push[i] && pop) begin
                    fill_d[i] = fill_q[i] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_HUNT;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (|sync_hit) begin
                        state_d = (&synced_d) ? ST_LOCKED : ST_PARTIAL;
                    end
                end
                ST_PARTIAL: begin
                    if (|overflow) begin
                        state_d = ST_ERROR;
                    end else if (&synced_d) begin
                        state_d = ST_LOCKED;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        enable_d   = pop;
        data_d     = pop ? head_word : data_q;
        data       = data_q;
        enable     = enable_q;
        locked     = (state_q == ST_LOCKED);
        sync_error = (state_q == ST_ERROR);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            synced_q <= '0;
            data_q   <= '0;
            enable_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                shift_q[i]   <= 8'h00;
                bit_cnt_q[i] <= 3'd0;
                fill_q[i]    <= '0;
                for (int j = 0; j < SKEW_BYTES; j++) begin
                    fifo_q[i][j] <= 8'h00;
                end
            end
        end else begin
            synced_q <= synced_d;
            data_q   <= data_d;
            enable_q <= enable_d;
            for (int i = 0; i < LANES; i++) begin
                shift_q[i]   <= shift_d[i];
                bit_cnt_q[i] <= bit_cnt_d[i];
                fill_q[i]    <= fill_d[i];
                for (int j = 0; j < SKEW_BYTES; j++) begin
                    fifo_q[i][j] <= fifo_d[i][j];
                end
            end
        end
    end

endmodule

// File: tb/tb_d_phy_multi_lane_receiver.sv
module tb_d_phy_multi_lane_receiver;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [1:0]  lane_bits = 2'b00;
    logic        stop = 1'b0;
    logic [15:0] data;
    logic        enable;
    logic        locked;
    logic        sync_error;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    d_phy_multi_lane_receiver #(
        .LANES(2),
        .SKEW_BYTES(2),
        .SYNC_BYTE(8'hB8)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .sample_valid(sample_valid),
        .lane_bits(lane_bits),
        .stop(stop),
        .data(data),
        .enable(enable),
        .locked(locked),
        .sync_error(sync_error)
    );

    always #5 clock = ~clock;

    // Byte k of a lane stream is l0[8k+:8]; expected word n is exp[16n+:16].
    typedef struct {
        logic [31:0] l0;
        logic [31:0] l1;
        int          nb;
        int          gap;
        int          nexp;
        logic [31:0] exp;
        logic        exp_locked;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard: every enable pulse must match the oldest expected word.
    always @(negedge clock) begin
        if (reset_n && enable) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%h required=none", data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("word", {16'h0, data}, {16'h0, e});
            end
        end
    end

    task automatic drive(input logic v, input logic [1:0] bits);
        sample_valid = v;
        lane_bits    = bits;
        @(posedge clock);
        #1;
    endtask

    task automatic send_bytes(input logic [31:0] l0, input logic [31:0] l1, input int nb, input int gap);
        for (int k = 0; k < nb; k++) begin
            for (int b = 0; b < 8; b++) begin
                for (int g = 1; g < gap; g++) drive(1'b0, 2'($urandom));
                drive(1'b1, {l1[8*k+b], l0[8*k+b]});
            end
        end
        sample_valid = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        drive(1'b1, 2'($urandom));
        stop = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) drive(1'b0, 2'b00);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h003412B8, 32'h003412B8, 3, 1, 2, 32'h34341212, 1'b1, 1'b0};
        vecs[1] = '{32'h00BBAAB8, 32'h00AAB800, 3, 1, 1, 32'h0000AAAA, 1'b1, 1'b0};
        vecs[2] = '{32'h00C3B8B8, 32'h00C3B8B8, 3, 1, 2, 32'hC3C3B8B8, 1'b1, 1'b0};
        vecs[3] = '{32'h332211B8, 32'hB8000000, 4, 1, 0, 32'h00000000, 1'b0, 1'b1};
        vecs[4] = '{32'h003412B8, 32'h003412B8, 3, 3, 2, 32'h34341212, 1'b1, 1'b0};
        vecs[5] = '{32'h000201B8, 32'h000FF0B8, 3, 1, 2, 32'h0F02F001, 1'b1, 1'b0};

        #12;
        check("rst_data", data, 0);
        check("rst_enable", enable, 0);
        check("rst_locked", locked, 0);
        check("rst_err", sync_error, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            do_stop();
            for (int n = 0; n < vecs[v].nexp; n++) exp_q.push_back(vecs[v].exp[16*n +: 16]);
            send_bytes(vecs[v].l0, vecs[v].l1, vecs[v].nb, vecs[v].gap);
            for (int c = 0; c < 3; c++) drive(1'b0, 2'b00);
            drain($sformatf("drain_v%0d", v));
            check($sformatf("locked_v%0d", v), locked, vecs[v].exp_locked);
            check($sformatf("err_v%0d", v), sync_error, vecs[v].exp_err);
        end

        // Latency: the last byte completes on edge E; enable is high after E+1 only.
        do_stop();
        exp_q.push_back(16'h1212);
        send_bytes(32'h000012B8, 32'h000012B8, 2, 1);
        check("lat_pre", enable, 0);
        drive(1'b0, 2'b00);
        check("lat_en", enable, 1);
        check("lat_data", data, 16'h1212);
        drive(1'b0, 2'b00);
        check("lat_pulse", enable, 0);
        check("lat_locked", locked, 1);
        do_stop();
        check("stop_locked", locked, 0);
        check("stop_data_hold", data, 16'h1212);

        // ERROR ignores lane traffic until stop, then recovers.
        send_bytes(32'h332211B8, 32'hB8000000, 4, 1);
        check("err_set", sync_error, 1);
        send_bytes(32'hB8B8B8B8, 32'h5A5A5A5A, 4, 1);
        check("err_hold", sync_error, 1);
        check("err_not_locked", locked, 0);
        do_stop();
        check("err_clear", sync_error, 0);
        exp_q.push_back(16'h6666);
        send_bytes(32'h000066B8, 32'h000066B8, 2, 1);
        drain("drain_err_recover");

        // stop in the middle of a word discards the partial bits.
        do_stop();
        send_bytes(32'h000000B8, 32'h000000B8, 1, 1);
        for (int b = 0; b < 4; b++) drive(1'b1, 2'b11);
        do_stop();
        exp_q.push_back(16'h5A5A);
        send_bytes(32'h00005AB8, 32'h00005AB8, 2, 1);
        drain("drain_stop_mid");

        // Asynchronous reset mid-word, then re-hunt.
        do_stop();
        exp_q.push_back(16'h2121);
        send_bytes(32'h000021B8, 32'h000021B8, 2, 1);
        drain("drain_pre_rst");
        for (int b = 0; b < 3; b++) drive(1'b1, 2'b10);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_data", data, 0);
        check("arst_enable", enable, 0);
        check("arst_locked", locked, 0);
        check("arst_err", sync_error, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        exp_q.push_back(16'h7777);
        send_bytes(32'h000077B8, 32'h000077B8, 2, 1);
        drain("drain_post_rst");
        check("post_rst_locked", locked, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/d_phy_multi_lane_receiver.md
D_PHY_MULTI_LANE_RECEIVER -- requirements
Module: d_phy_multi_lane_receiver

Interface
REQ-001 SHALL have parameter LANES, default 2, number of HS data lanes (1..4).
REQ-002 SHALL have parameter SKEW_BYTES, default 2, per-lane deskew FIFO depth in bytes (1..4).
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hB8, HS sync pattern in byte order.
REQ-004 SHALL have port clock  input  1  single bit-rate clock, rising edge; all logic in this domain.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port sample_valid  input  1  one HS bit per lane present on lane_bits this cycle.
REQ-007 SHALL have port lane_bits  input  LANES  HS bit per lane; bit i = lane i.
REQ-008 SHALL have port stop  input  1  synchronous end-of-burst clear from protocol layer.
REQ-009 SHALL have port data  output  8*LANES  aligned byte word; bits [8i+7:8i] = lane i.
REQ-010 SHALL have port enable  output  1  data valid, one-cycle pulse per word.
REQ-011 SHALL have port locked  output  1  all lanes synchronized, state LOCKED.
REQ-012 SHALL have port sync_error  output  1  sticky lane-skew error, state ERROR.

Function
REQ-013 Each lane SHALL shift its bit in LSB-first (new bit into bit 7, shift right) only on cycles with sample_valid=1.
REQ-014 A hunting lane SHALL declare sync on the edge where its shift register equals SYNC_BYTE, then set its bit counter to 0.
REQ-015 A synced lane SHALL complete a byte on every 8th subsequent sample_valid edge and push it into its deskew FIFO on that same edge.
REQ-016 A hunting lane SHALL ignore further matches only after sync; after sync, SYNC_BYTE patterns in payload SHALL NOT re-trigger sync.
REQ-017 States SHALL be HUNT (no lane synced), PARTIAL (1..LANES-1 synced), LOCKED (all synced), ERROR.
REQ-018 Transitions: HUNT->PARTIAL on first lane sync; PARTIAL->LOCKED when last lane syncs; HUNT->LOCKED directly if all lanes sync on the same edge; any state->HUNT on stop=1.
REQ-019 PARTIAL->ERROR SHALL occur when a lane completes a byte while its FIFO already holds SKEW_BYTES entries.
REQ-020 ERROR SHALL be held, ignoring lane_bits, until stop=1.
REQ-021 When every lane FIFO is non-empty, all FIFOs SHALL pop one byte simultaneously; data and enable register on that edge.
REQ-022 Latency: the last lane's byte completes on edge E, so enable SHALL be high during the cycle after edge E+1.
REQ-023 Simultaneous push and pop on one FIFO SHALL keep its occupancy unchanged and SHALL NOT count as overflow.
REQ-024 enable SHALL be 0 in HUNT, PARTIAL-without-pop and ERROR; data SHALL hold its last value when enable=0.
REQ-025 stop=1 SHALL clear shift registers, counters and FIFOs, deassert enable, locked and sync_error next edge, and override sample_valid that cycle.
REQ-026 LANES=1 SHALL behave as HUNT->LOCKED with no ERROR reachable.

Reset
REQ-027 reset_n=0 SHALL asynchronously force state HUNT, all shift registers to 8'h00, counters to 0, and FIFOs empty.
REQ-028 reset_n=0 SHALL asynchronously force data=0, enable=0, locked=0 and sync_error=0.
REQ-029 Reset asserted mid-burst SHALL discard partial bytes; after release, the block SHALL re-hunt for SYNC_BYTE.

Verification
REQ-030 LANES=2, both lanes send B8,12,34 aligned -> locked=1; enable pulses twice, data=16'h1212 then 16'h3434.
REQ-031 Lane 1 sync 1 byte after lane 0 (lane0 B8,AA,BB; lane1 B8,AA) -> one word 16'hAAAA, no error; lane0 BB held pending.
REQ-032 Lane 1 sync 3 bytes after lane 0 with SKEW_BYTES=2 -> sync_error=1, enable stays 0 until stop.
REQ-033 Payload byte B8 after lock -> output word 16'hB8B8, no resync, bit phase unchanged.
REQ-034 stop pulse mid-word, then fresh B8,5A on both lanes -> partial word dropped; next output 16'h5A5A.
REQ-035 sample_valid gaps (1 of every 3 cycles) -> identical words to REQ-030; reset_n low mid-word -> all outputs 0 immediately.
